// File: rtl/wb_mailbox_slave.sv
// Wishbone register slave with ID/STATUS/CONTROL/scratch registers and two
// first-word-fall-through mailbox FIFOs between the host and fabric logic.
module wb_mailbox_slave #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 16,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] ID_VALUE   = 16'hB3E1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] wbs_address,
  input  logic [DATA_WIDTH-1:0] wbs_writedata,
  output logic [DATA_WIDTH-1:0] wbs_readdata,
  input  logic                  wbs_write,
  input  logic                  wbs_strobe,
  input  logic                  wbs_cycle,
  output logic                  wbs_ack,
  output logic [DATA_WIDTH-1:0] h2f_data,
  output logic                  h2f_valid,
  input  logic                  h2f_ready,
  input  logic [DATA_WIDTH-1:0] f2h_data,
  input  logic                  f2h_valid,
  output logic                  f2h_ready,
  output logic                  irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] h2f_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] f2h_mem [FIFO_DEPTH];
  logic [PW-1:0]         h2f_wptr, h2f_rptr, f2h_wptr, f2h_rptr;
  logic [CW-1:0]         h2f_count, f2h_count;
  logic [DATA_WIDTH-1:0] scratch [4];
  logic                  irq_en, overflow, underflow;

  logic                  unused_cycle;
  assign unused_cycle = wbs_cycle;

  // ---------------------------------------------------------------- decode
  logic       access, mapped, is_data;
  logic [2:0] reg_sel;
  logic       h2f_full, h2f_empty, f2h_full, f2h_empty;
  logic       host_push, host_pop, ovf_evt, unf_evt, do_clear;
  logic       fab_push, fab_pop;

  assign access    = (state == S_ACK);
  assign mapped    = (wbs_address[ADDR_WIDTH-1:3] == '0);
  assign reg_sel   = wbs_address[2:0];
  assign is_data   = access & mapped & (reg_sel == 3'd3);

  assign h2f_full  = (h2f_count == CW'(FIFO_DEPTH));
  assign h2f_empty = (h2f_count == '0);
  assign f2h_full  = (f2h_count == CW'(FIFO_DEPTH));
  assign f2h_empty = (f2h_count == '0);

  assign host_push = is_data &  wbs_write & ~h2f_full;
  assign ovf_evt   = is_data &  wbs_write &  h2f_full;
  assign host_pop  = is_data & ~wbs_write & ~f2h_empty;
  assign unf_evt   = is_data & ~wbs_write &  f2h_empty;
  assign do_clear  = access & mapped & wbs_write & (reg_sel == 3'd2) & wbs_writedata[0];

  assign fab_pop   = h2f_valid & h2f_ready;
  assign fab_push  = f2h_valid & f2h_ready;

  assign h2f_valid = ~h2f_empty;
  assign h2f_data  = h2f_valid ? h2f_mem[h2f_rptr] : '0;
  assign f2h_ready = ~f2h_full;
  assign irq       = irq_en & ~f2h_empty;

  // ----------------------------------------------------------------- FIFOs
  // NOTE: the FIFO storage has no reset; the counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (host_push)           h2f_mem[h2f_wptr] <= wbs_writedata;
    if (fab_push & ~do_clear) f2h_mem[f2h_wptr] <= f2h_data;
  end

  // Clear takes priority over any fabric-side push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h2f_wptr  <= '0;
      h2f_rptr  <= '0;
      h2f_count <= '0;
      f2h_wptr  <= '0;
      f2h_rptr  <= '0;
      f2h_count <= '0;
    end else if (do_clear) begin
      h2f_wptr  <= '0;
      h2f_rptr  <= '0;
      h2f_count <= '0;
      f2h_wptr  <= '0;
      f2h_rptr  <= '0;
      f2h_count <= '0;
    end else begin
      if (host_push) h2f_wptr <= h2f_wptr + PW'(1);
      if (fab_pop)   h2f_rptr <= h2f_rptr + PW'(1);
      h2f_count <= h2f_count + CW'(host_push) - CW'(fab_pop);
      if (fab_push)  f2h_wptr <= f2h_wptr + PW'(1);
      if (host_pop)  f2h_rptr <= f2h_rptr + PW'(1);
      f2h_count <= f2h_count + CW'(fab_push) - CW'(host_pop);
    end
  end

  // ------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < 4; i++) scratch[i] <= '0;
    end else begin
      if (access & mapped & wbs_write) begin
        if (reg_sel == 3'd2) irq_en <= wbs_writedata[1];
        if (reg_sel[2])      scratch[reg_sel[1:0]] <= wbs_writedata;
      end
      if (do_clear) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        overflow  <= overflow  | ovf_evt;
        underflow <= underflow | unf_evt;
      end
    end
  end

  // Read mux; write accesses load zero into the read-data register.
  logic [15:0]           status;
  logic [DATA_WIDTH-1:0] rd_next;

  assign status = {2'b00, underflow, overflow, f2h_empty, h2f_full,
                   5'(f2h_count), 5'(h2f_count)};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_next = '0;
    if (mapped && !wbs_write) begin
      case (reg_sel)
        3'd0:    rd_next = DATA_WIDTH'(ID_VALUE);
        3'd1:    rd_next = DATA_WIDTH'(status);
        3'd2:    rd_next = DATA_WIDTH'({irq_en, 1'b0});
        3'd3:    if (!f2h_empty) rd_next = f2h_mem[f2h_rptr];
        default: rd_next = scratch[reg_sel[1:0]];
      endcase
    end
  end

  // ------------------------------------------------------------ access FSM
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wbs_ack      <= 1'b0;
      wbs_readdata <= '0;
    end else begin
      wbs_ack <= 1'b0;
      case (state)
        S_IDLE: if (wbs_strobe) state <= S_ACK;
        S_ACK: begin
          wbs_ack      <= 1'b1;
          wbs_readdata <= rd_next;
          state        <= S_WAIT;
        end
        S_WAIT: if (!wbs_strobe) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mailbox_slave.sv
// Self-checking bench for wb_mailbox_slave: directed scenarios plus random
// traffic, compared against a queue-based model of the mailbox rules.
module tb_wb_mailbox_slave;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] wbs_address, wbs_writedata, wbs_readdata;
  logic        wbs_write, wbs_strobe, wbs_cycle, wbs_ack;
  logic [15:0] h2f_data, f2h_data;
  logic        h2f_valid, h2f_ready, f2h_valid, f2h_ready, irq;

  always #5 clk = ~clk;

  wb_mailbox_slave dut (
    .clk(clk), .reset(reset),
    .wbs_address(wbs_address), .wbs_writedata(wbs_writedata),
    .wbs_readdata(wbs_readdata), .wbs_write(wbs_write),
    .wbs_strobe(wbs_strobe), .wbs_cycle(wbs_cycle), .wbs_ack(wbs_ack),
    .h2f_data(h2f_data), .h2f_valid(h2f_valid), .h2f_ready(h2f_ready),
    .f2h_data(f2h_data), .f2h_valid(f2h_valid), .f2h_ready(f2h_ready),
    .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] m_h2f [$];
  logic [15:0] m_f2h [$];
  bit          m_ovf, m_unf, m_irq_en;
  logic [15:0] m_scr [4];
  logic [15:0] exp_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h2f.delete();
    m_f2h.delete();
    m_ovf = 0; m_unf = 0; m_irq_en = 0;
    for (int i = 0; i < 4; i++) m_scr[i] = '0;
    exp_rd = '0;
  endtask

  // One clock: apply the edge to the model (act = host register action at
  // this edge), then check fabric-side outputs on the falling edge.
  task automatic step(input bit act);
    int  pre_h, pre_f;
    bit  f_push, f_pop, h_push, h_pop, clr;
    @(posedge clk);
    pre_h  = m_h2f.size();
    pre_f  = m_f2h.size();
    f_push = f2h_valid && (pre_f < D);
    f_pop  = h2f_ready && (pre_h > 0);
    h_push = 0; h_pop = 0; clr = 0;
    if (act) begin
      exp_rd = '0;
      if (wbs_address < 16'd8) begin
        case (wbs_address[2:0])
          3'd0: if (!wbs_write) exp_rd = 16'hB3E1;
          3'd1: if (!wbs_write)
                  exp_rd = {2'b00, m_unf, m_ovf, pre_f == 0, pre_h == D,
                            5'(pre_f), 5'(pre_h)};
          3'd2: if (wbs_write) begin
                  m_irq_en = wbs_writedata[1];
                  clr      = wbs_writedata[0];
                end else exp_rd = {14'd0, m_irq_en, 1'b0};
          3'd3: if (wbs_write) begin
                  if (pre_h < D) h_push = 1; else m_ovf = 1;
                end else begin
                  if (pre_f > 0) begin exp_rd = m_f2h[0]; h_pop = 1; end
                  else m_unf = 1;
                end
          default: if (wbs_write) m_scr[wbs_address[1:0]] = wbs_writedata;
                   else exp_rd = m_scr[wbs_address[1:0]];
        endcase
      end
    end
    if (clr) begin
      m_h2f.delete(); m_f2h.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      if (f_pop)  void'(m_h2f.pop_front());
      if (h_pop)  void'(m_f2h.pop_front());
      if (h_push) m_h2f.push_back(wbs_writedata);
      if (f_push) m_f2h.push_back(f2h_data);
    end
    @(negedge clk);
    check("h2f_valid", h2f_valid, m_h2f.size() > 0);
    check("h2f_data", h2f_data, (m_h2f.size() > 0) ? m_h2f[0] : 16'h0);
    check("f2h_ready", f2h_ready, m_f2h.size() < D);
    check("irq", irq, m_irq_en && (m_f2h.size() > 0));
  endtask

  task automatic wb_access(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                           input int hold, input bit push_act, input logic [15:0] push_word,
                           output logic [15:0] rd);
    wbs_write = we; wbs_address = addr; wbs_writedata = wd;
    wbs_strobe = 1; wbs_cycle = 1;
    step(0);
    check("ack_early", wbs_ack, 1'b0);
    if (push_act) begin f2h_valid = 1; f2h_data = push_word; end
    step(1);
    if (push_act) f2h_valid = 0;
    check("ack", wbs_ack, 1'b1);
    check("readdata", wbs_readdata, exp_rd);
    rd = wbs_readdata;
    for (int i = 0; i < hold; i++) begin
      step(0);
      check("ack_held", wbs_ack, 1'b0);
    end
    wbs_strobe = 0; wbs_cycle = 0;
    step(0);
    check("ack_drop", wbs_ack, 1'b0);
  endtask

  task automatic wb_write(input logic [15:0] addr, input logic [15:0] wd);
    logic [15:0] rd;
    wb_access(1, addr, wd, 0, 0, 16'h0, rd);
  endtask

  task automatic wb_read(input logic [15:0] addr, output logic [15:0] rd);
    wb_access(0, addr, 16'h0, 0, 0, 16'h0, rd);
  endtask

  task automatic fab_push(input logic [15:0] w);
    f2h_valid = 1; f2h_data = w;
    step(0);
    f2h_valid = 0;
  endtask

  initial begin
    logic [15:0] rd, wd, addr;
    bit          we;

    model_reset();
    reset = 0;
    wbs_address = '0; wbs_writedata = '0; wbs_write = 0;
    wbs_strobe = 0; wbs_cycle = 0;
    h2f_ready = 0; f2h_valid = 0; f2h_data = '0;
    #1;
    check("rst_ack", wbs_ack, 1'b0);
    check("rst_readdata", wbs_readdata, 16'h0);
    check("rst_h2f_valid", h2f_valid, 1'b0);
    check("rst_h2f_data", h2f_data, 16'h0);
    check("rst_f2h_ready", f2h_ready, 1'b1);
    check("rst_irq", irq, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1;
    @(negedge clk);

    // ID, scratch, single ack with a long strobe
    wb_read(16'd0, rd);
    check("id", rd, 16'hB3E1);
    wb_write(16'd5, 16'h5A5A);
    wb_access(0, 16'd5, 16'h0, 10, 0, 16'h0, rd);
    check("scratch5", rd, 16'h5A5A);

    // h2f fill and overflow, then ordered drain
    for (int i = 1; i <= 17; i++) wb_write(16'd3, 16'(i));
    wb_read(16'd1, rd);
    check("status_full", rd, 16'h1C10);
    h2f_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      check("h2f_order", h2f_data, i);
      step(0);
    end
    h2f_ready = 0;

    // f2h with interrupt, drain and underflow
    wb_write(16'd2, 16'h0002);
    fab_push(16'hA001); fab_push(16'hA002); fab_push(16'hA003);
    check("irq_up", irq, 1'b1);
    wb_read(16'd3, rd); check("f2h_0", rd, 16'hA001);
    wb_read(16'd3, rd); check("f2h_1", rd, 16'hA002);
    wb_read(16'd3, rd); check("f2h_2", rd, 16'hA003);
    check("irq_down", irq, 1'b0);
    wb_read(16'd3, rd); check("f2h_empty_rd", rd, 16'h0);
    wb_read(16'd1, rd); check("underflow_bit", rd[13], 1'b1);

    // Pointer wrap with same-cycle push and pop at count 5
    for (int i = 0; i < 14; i++) fab_push(16'hB000 + 16'(i));
    for (int i = 0; i < 9; i++) wb_read(16'd3, rd);
    for (int i = 0; i < 6; i++) wb_access(0, 16'd3, 16'h0, 0, 1, 16'hC000 + 16'(i), rd);
    wb_read(16'd1, rd);
    check("f2h_count_5", rd[9:5], 5'd5);

    // Clear with both FIFOs partly full
    fab_push(16'h1111);
    wb_write(16'd3, 16'h2222); wb_write(16'd3, 16'h3333);
    wb_write(16'd2, 16'h0003);
    wb_read(16'd1, rd); check("status_clear", rd, 16'h0800);
    wb_read(16'd2, rd); check("control_rd", rd, 16'h0002);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      h2f_ready = ($urandom_range(0, 3) == 0);
      f2h_valid = $urandom_range(0, 1);
      f2h_data  = 16'($urandom);
      addr = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) addr = 16'h8003;
      we = $urandom_range(0, 1);
      wd = 16'($urandom);
      if (addr == 16'd2) wd[0] = ($urandom_range(0, 7) == 0);
      wb_access(we, addr, wd, $urandom_range(0, 2), 0, 16'h0, rd);
      for (int k = $urandom_range(0, 2); k > 0; k--) step(0);
    end
    h2f_ready = 0; f2h_valid = 0;
    wb_write(16'd2, 16'h0001);

    // Reset in the WAIT state
    wbs_write = 0; wbs_address = 16'd1; wbs_strobe = 1; wbs_cycle = 1;
    step(0);
    step(1);
    check("pre_rst_ack", wbs_ack, 1'b1);
    step(0);
    #2 reset = 0;
    #1;
    check("rst_mid_ack", wbs_ack, 1'b0);
    check("rst_mid_readdata", wbs_readdata, 16'h0);
    wbs_strobe = 0; wbs_cycle = 0;
    model_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    wb_read(16'd1, rd);
    check("status_after_rst", rd, 16'h0800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
